uart_pkt_rx: RTL and testbench
==============================

Name: uart_pkt_rx

Overview:
- Downstream consumer of the UART byte receiver. Takes its 8-bit data plus single-cycle valid strobe and deframes packets.
- Frame format: SYNC byte 0xA5, LEN, LEN payload bytes, CHK.
- A good payload is buffered, then replayed on a valid/ready byte stream with a last flag.
- Framing errors are flagged and the block resynchronises on the next SYNC.

Parameters:
- MAX_LEN, 16: largest accepted payload length in bytes (1..255); sets buffer depth.
- TIMEOUT_CYC, 52083: max clk cycles between bytes mid-frame (about 10 bit times at 50 MHz / 9600 baud); used only with the optional feature.

Ports:
- clk  in  1  single clock
- nrst  in  1  asynchronous active-low reset
- in_data  in  8  received byte
- in_v  in  1  one-cycle strobe, in_data valid; no backpressure
- out_data  out  8  payload byte
- out_v  out  1  payload byte valid
- out_last  out  1  marks final payload byte, qualified by out_v
- out_rdy  in  1  downstream accepts out_data when out_v && out_rdy
- frame_ok  out  1  one-cycle pulse, good frame accepted
- frame_err  out  1  one-cycle pulse, frame or byte rejected
- err_code  out  2  cause, valid with frame_err: 0 BADLEN, 1 CHKSUM, 2 OVERRUN, 3 TIMEOUT

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (nrst).
  - State HUNT; idx, len, sum and rd cleared.
  - out_v, out_last, frame_ok, frame_err = 0; err_code = 0; out_data = 0.
  - Reset mid-frame or mid-drain discards everything and returns to HUNT.
- FSM states: HUNT, LEN, PAY, CHK, OUT.
  - Only bytes with in_v=1 advance the FSM; each is consumed on the clk edge where in_v=1.
- HUNT:
  - in_data==0xA5 -> LEN.
  - Any other byte is silently ignored (no error).
- LEN:
  - Byte 0 or byte > MAX_LEN -> frame_err, err_code=BADLEN, go to HUNT. That byte is not re-checked as SYNC.
  - Otherwise: len <= byte, sum <= byte, idx <= 0, go to PAY.
- PAY:
  - Each byte: buf[idx] <= byte, sum <= sum + byte (8-bit, mod 256), idx++.
  - Byte with idx==len-1 -> CHK.
- CHK:
  - byte==sum -> OUT, rd <= 0, frame_ok pulses the following cycle.
  - Else frame_err, err_code=CHKSUM, go to HUNT; buffer contents discarded.
- OUT:
  - out_v=1 from the cycle after the CHK byte.
  - out_data = buf[rd], combinational read of the register array; out_last = (rd==len-1).
  - Transfer on out_v && out_rdy: rd++.
  - Transfer with out_last -> HUNT next cycle with out_v=0.
  - out_data and out_last are held stable while out_v && !out_rdy.
- Overrun: an in_v byte arriving in OUT is dropped and frame_err pulses with err_code=OVERRUN, once per dropped byte.
  - Draining continues unaffected.
  - A SYNC arriving in OUT is also dropped.
- Simultaneous events:
  - Final out transfer plus in_v in the same cycle: byte counts as an OVERRUN.
  - If frame_err and frame_ok would coincide, frame_err wins; this cannot occur in normal operation.
- Widths: idx, rd and len use $clog2(MAX_LEN+1) bits; sum is 8 bits.

Optional Feature:
- Macro: UART_PKT_TIMEOUT_EN.
- When defined:
  - A counter counts cycles since the last in_v while in LEN, PAY or CHK; it is reloaded on every in_v.
  - Reaching TIMEOUT_CYC -> frame_err, err_code=TIMEOUT, go to HUNT.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- When undefined:
  - No counter logic; the FSM waits indefinitely for the next byte.
  - err_code 3 is never produced.

Decomposition:
- Package uart_pkt_pkg holds:
  - SYNC_BYTE = 8'hA5
  - state enum {HUNT, LEN, PAY, CHK, OUT}
  - err_code constants ERR_BADLEN, ERR_CHKSUM, ERR_OVERRUN, ERR_TIMEOUT
- One sub-module, uart_pkt_buf: MAX_LEN x 8 register array with synchronous write port and combinational read port. Not reset; contents are don't-care after reset.

Test Plan:
- Bytes A5 03 11 22 33 69, out_rdy=1 -> frame_ok once; out stream 11, 22, 33 with out_last on 33; no frame_err.
- Same frame with CHK=68 -> frame_err, err_code=1, no out_v. Then A5 01 7E 7F -> out 7E with out_last.
- Bytes 00 A5 00 A5 02 01 02 05 -> first A5 00 gives BADLEN (code 0); the following A5 frame passes, out 01, 02.
- Good 3-byte frame, out_rdy=0 for 20 cycles, two bytes arriving meanwhile -> two OVERRUN pulses (code 2); after out_rdy=1, 11, 22, 33 delivered intact.
- With UART_PKT_TIMEOUT_EN and TIMEOUT_CYC=100: A5 02 11 then silence -> frame_err with code 3 exactly 100 cycles after the 11 strobe. Next A5 01 05 06 frame succeeds.
- nrst asserted while in PAY and again with out_v=1 -> all outputs 0 immediately (asynchronous); the next full frame decodes correctly.

Source files
------------

// File: rtl/uart_pkt_rx_pkg.sv
// Shared constants and types for the UART packet deframer.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {HUNT, LEN, PAY, CHK, OUT} state_t;

  localparam logic [1:0] ERR_BADLEN  = 2'd0;
  localparam logic [1:0] ERR_CHKSUM  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_pkt_rx_if.sv
// Byte-in / payload-out / status bundle of the packet deframer.
interface uart_pkt_rx_if;
  logic [7:0] in_data;
  logic       in_v;
  logic [7:0] out_data;
  logic       out_v;
  logic       out_last;
  logic       out_rdy;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    input  in_data, in_v, out_rdy,
    output out_data, out_v, out_last, frame_ok, frame_err, err_code
  );

  modport slave (
    output in_data, in_v, out_rdy,
    input  out_data, out_v, out_last, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_pkt_buf.sv
// Payload store: MAX_LEN x 8 registers, synchronous write, combinational read, no reset.
module uart_pkt_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet deframer: SYNC(A5) LEN payload CHK -> buffered payload replayed on valid/ready.
// Optional inter-byte timeout enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 52083
) (
  input logic           clk,
  input logic           nrst,
  uart_pkt_rx_if.master bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx, len, len_nx, rd, rd_nx;
  logic [7:0]      sum, sum_nx;
  logic            frame_ok_q, frame_err_q, ok_nx, err_nx;
  logic [1:0]      err_code_q, code_nx;
  logic [7:0]      rd_data;
  logic            out_v, out_last, wr_en;

  assign out_v    = (state == OUT);
  assign out_last = out_v && ((rd + IW'(1)) == len);
  assign wr_en    = bus.in_v && (state == PAY);

  uart_pkt_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx[AW-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd[AW-1:0]),
    .rd_data (rd_data)
  );

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = (state == LEN) || (state == PAY) || (state == CHK);

  // Holds the number of cycles since the last strobe; 1 in the cycle after it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                         tmo_cnt <= '0;
    else if (!in_frame)                tmo_cnt <= '0;
    else if (bus.in_v)                 tmo_cnt <= TW'(1);
    else if (tmo_cnt != TW'(TIMEOUT_CYC)) tmo_cnt <= tmo_cnt + TW'(1);
  end
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    len_nx   = len;
    sum_nx   = sum;
    rd_nx    = rd;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    code_nx  = ERR_BADLEN;
    case (state)
      HUNT: if (bus.in_v && (bus.in_data == SYNC_BYTE)) state_nx = LEN;
      LEN: if (bus.in_v) begin
        if ((bus.in_data == 8'd0) || (bus.in_data > MAX_LEN_B)) begin
          err_nx   = 1'b1;
          code_nx  = ERR_BADLEN;
          state_nx = HUNT;
        end else begin
          len_nx   = bus.in_data[IW-1:0];
          sum_nx   = bus.in_data;
          idx_nx   = '0;
          state_nx = PAY;
        end
      end
      PAY: if (bus.in_v) begin
        sum_nx = sum + bus.in_data;
        idx_nx = idx + IW'(1);
        if ((idx + IW'(1)) == len) state_nx = CHK;
      end
      CHK: if (bus.in_v) begin
        if (bus.in_data == sum) begin
          rd_nx    = '0;
          ok_nx    = 1'b1;
          state_nx = OUT;
        end else begin
          err_nx   = 1'b1;
          code_nx  = ERR_CHKSUM;
          state_nx = HUNT;
        end
      end
      OUT: begin
        // No backpressure on the byte side: anything arriving now is lost.
        if (bus.in_v) begin
          err_nx  = 1'b1;
          code_nx = ERR_OVERRUN;
        end
        if (bus.out_rdy) begin
          rd_nx = rd + IW'(1);
          if (out_last) state_nx = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
`ifdef UART_PKT_TIMEOUT_EN
    if (in_frame && !bus.in_v && (tmo_cnt == TW'(TIMEOUT_CYC - 1))) begin
      err_nx   = 1'b1;
      code_nx  = ERR_TIMEOUT;
      ok_nx    = 1'b0;
      state_nx = HUNT;
    end
`endif
    if (err_nx) ok_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= HUNT;
      idx         <= '0;
      len         <= '0;
      sum         <= '0;
      rd          <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_BADLEN;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      len         <= len_nx;
      sum         <= sum_nx;
      rd          <= rd_nx;
      frame_ok_q  <= ok_nx;
      frame_err_q <= err_nx;
      err_code_q  <= code_nx;
    end
  end

  assign bus.out_v     = out_v;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_v ? rd_data : 8'h00;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed self-checking bench for uart_pkt_rx (timeout path when UART_PKT_TIMEOUT_EN is defined).
module tb_uart_pkt_rx;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;

  int   ok_cnt, err_cnt, ovr_cnt, err_cyc;
  logic [1:0] last_code;
  logic [8:0] out_q[$];

  uart_pkt_rx_if bus();

  uart_pkt_rx #(.MAX_LEN(16), .TIMEOUT_CYC(100)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_ok) ok_cnt++;
    if (bus.frame_err) begin
      err_cnt++;
      last_code = bus.err_code;
      err_cyc = cyc;
      if (bus.err_code == 2'd2) ovr_cnt++;
    end
    if (bus.out_v && bus.out_rdy) out_q.push_back({bus.out_last, bus.out_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear();
    ok_cnt = 0; err_cnt = 0; ovr_cnt = 0; err_cyc = 0; last_code = 2'd0;
    out_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    bus.in_data = b; bus.in_v = 1'b1;
    @(posedge clk); #2;
    bus.in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #2;
    nchk++;
    if ({bus.out_v, bus.out_last, bus.frame_ok, bus.frame_err, bus.err_code, bus.out_data} !== 14'd0) begin
      nfail++;
      $display("FAIL reset_outputs got v=%b l=%b ok=%b err=%b code=%0d data=%h want all 0",
               bus.out_v, bus.out_last, bus.frame_ok, bus.frame_err, bus.err_code, bus.out_data);
    end
    idle(3);
    nrst = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    clear();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h69);
    idle(8);
    nchk++; if (ok_cnt !== 1) begin nfail++; $display("FAIL good_ok_cnt got %0d want 1", ok_cnt); end
    nchk++; if (err_cnt !== 0) begin nfail++; $display("FAIL good_err_cnt got %0d want 0", err_cnt); end
    nchk++; if (out_q.size() !== 3) begin nfail++; $display("FAIL good_out_len got %0d want 3", out_q.size()); end
    nchk++; if (out_q[0] !== 9'h011) begin nfail++; $display("FAIL good_out0 got %h want 011", out_q[0]); end
    nchk++; if (out_q[1] !== 9'h022) begin nfail++; $display("FAIL good_out1 got %h want 022", out_q[1]); end
    nchk++; if (out_q[2] !== 9'h133) begin nfail++; $display("FAIL good_out2 got %h want 133", out_q[2]); end
  endtask

  task automatic test_bad_checksum();
    clear();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h68);
    idle(6);
    nchk++; if (err_cnt !== 1) begin nfail++; $display("FAIL chk_err_cnt got %0d want 1", err_cnt); end
    nchk++; if (last_code !== 2'd1) begin nfail++; $display("FAIL chk_code got %0d want 1", last_code); end
    nchk++; if (out_q.size() !== 0 || ok_cnt !== 0) begin nfail++; $display("FAIL chk_no_out got out=%0d ok=%0d want 0 0", out_q.size(), ok_cnt); end
    clear();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    idle(6);
    nchk++; if (ok_cnt !== 1) begin nfail++; $display("FAIL chk_next_ok got %0d want 1", ok_cnt); end
    nchk++; if (out_q.size() !== 1 || out_q[0] !== 9'h17E) begin nfail++; $display("FAIL chk_next_out got n=%0d %h want 1 17e", out_q.size(), out_q[0]); end
  endtask

  task automatic test_badlen();
    clear();
    send_byte(8'h00); send_byte(8'hA5); send_byte(8'h00); send_byte(8'hA5);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    idle(6);
    nchk++; if (err_cnt !== 1 || last_code !== 2'd0) begin nfail++; $display("FAIL badlen_err got n=%0d code=%0d want 1 0", err_cnt, last_code); end
    nchk++; if (ok_cnt !== 1) begin nfail++; $display("FAIL badlen_ok got %0d want 1", ok_cnt); end
    nchk++; if (out_q.size() !== 2 || out_q[0] !== 9'h001 || out_q[1] !== 9'h102) begin
      nfail++; $display("FAIL badlen_out got n=%0d %h %h want 2 001 102", out_q.size(), out_q[0], out_q[1]);
    end
  endtask

  task automatic test_max_len();
    clear();
    send_byte(8'hA5); send_byte(8'h11);
    idle(3);
    nchk++; if (err_cnt !== 1 || last_code !== 2'd0) begin nfail++; $display("FAIL maxlen_over got n=%0d code=%0d want 1 0", err_cnt, last_code); end
    clear();
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);
    idle(20);
    nchk++; if (ok_cnt !== 1 || err_cnt !== 0) begin nfail++; $display("FAIL maxlen_ok got ok=%0d err=%0d want 1 0", ok_cnt, err_cnt); end
    nchk++; if (out_q.size() !== 16 || out_q[0] !== 9'h001 || out_q[15] !== 9'h110) begin
      nfail++; $display("FAIL maxlen_out got n=%0d %h %h want 16 001 110", out_q.size(), out_q[0], out_q[15]);
    end
  endtask

  task automatic test_overrun_stall();
    clear();
    bus.out_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h69);
    send_byte(8'h55); send_byte(8'hA5);
    idle(14);
    nchk++; if (bus.out_v !== 1'b1 || bus.out_data !== 8'h11 || bus.out_last !== 1'b0) begin
      nfail++; $display("FAIL stall_hold got v=%b d=%h l=%b want 1 11 0", bus.out_v, bus.out_data, bus.out_last);
    end
    nchk++; if (err_cnt !== 2 || ovr_cnt !== 2) begin nfail++; $display("FAIL stall_overrun got err=%0d ovr=%0d want 2 2", err_cnt, ovr_cnt); end
    bus.out_rdy = 1'b1;
    idle(6);
    nchk++; if (out_q.size() !== 3 || out_q[0] !== 9'h011 || out_q[1] !== 9'h022 || out_q[2] !== 9'h133) begin
      nfail++; $display("FAIL stall_out got n=%0d %h %h %h want 3 011 022 133", out_q.size(), out_q[0], out_q[1], out_q[2]);
    end
    nchk++; if (bus.out_v !== 1'b0) begin nfail++; $display("FAIL stall_done got v=%b want 0", bus.out_v); end
  endtask

  task automatic test_back_to_back();
    clear();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h69);
    @(posedge clk);
    send_byte(8'hA5);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    idle(6);
    nchk++; if (err_cnt !== 1 || last_code !== 2'd2) begin nfail++; $display("FAIL b2b_overrun got n=%0d code=%0d want 1 2", err_cnt, last_code); end
    nchk++; if (ok_cnt !== 2 || out_q.size() !== 4 || out_q[3] !== 9'h17E) begin
      nfail++; $display("FAIL b2b_out got ok=%0d n=%0d %h want 2 4 17e", ok_cnt, out_q.size(), out_q[3]);
    end
  endtask

  task automatic test_timeout();
    int s;
    clear();
    send_byte(8'hA5); send_byte(8'h02);
    @(posedge clk); #2;
    bus.in_data = 8'h11; bus.in_v = 1'b1; s = cyc;
    @(posedge clk); #2;
    bus.in_v = 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
    for (int i = 0; i < 150 && err_cnt == 0; i++) @(posedge clk);
    idle(2);
    nchk++; if (err_cnt !== 1 || last_code !== 2'd3) begin nfail++; $display("FAIL tmo_err got n=%0d code=%0d want 1 3", err_cnt, last_code); end
    nchk++; if (err_cyc !== s + 100) begin nfail++; $display("FAIL tmo_cycle got %0d want %0d", err_cyc - s, 100); end
    clear();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    idle(6);
    nchk++; if (ok_cnt !== 1 || out_q.size() !== 1 || out_q[0] !== 9'h105) begin
      nfail++; $display("FAIL tmo_next got ok=%0d n=%0d %h want 1 1 105", ok_cnt, out_q.size(), out_q[0]);
    end
`else
    idle(150);
    nchk++; if (err_cnt !== 0) begin nfail++; $display("FAIL notmo_err got %0d want 0 (s=%0d)", err_cnt, s); end
    send_byte(8'h22); send_byte(8'h35);
    idle(6);
    nchk++; if (ok_cnt !== 1 || out_q.size() !== 2 || out_q[0] !== 9'h011 || out_q[1] !== 9'h122) begin
      nfail++; $display("FAIL notmo_out got ok=%0d n=%0d %h %h want 1 2 011 122", ok_cnt, out_q.size(), out_q[0], out_q[1]);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    clear();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    nrst = 1'b0;
    #1;
    nchk++; if ({bus.out_v, bus.frame_ok, bus.frame_err, bus.out_data} !== 11'd0) begin
      nfail++; $display("FAIL rst_pay got v=%b ok=%b err=%b d=%h want 0", bus.out_v, bus.frame_ok, bus.frame_err, bus.out_data);
    end
    idle(2);
    nrst = 1'b1;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    idle(6);
    nchk++; if (ok_cnt !== 0 || err_cnt !== 0 || out_q.size() !== 0) begin
      nfail++; $display("FAIL rst_pay_discard got ok=%0d err=%0d n=%0d want 0 0 0", ok_cnt, err_cnt, out_q.size());
    end
    bus.out_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    idle(2);
    nchk++; if (bus.out_v !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== 8'h7E) begin
      nfail++; $display("FAIL rst_out_pre got v=%b l=%b d=%h want 1 1 7e", bus.out_v, bus.out_last, bus.out_data);
    end
    nrst = 1'b0;
    #1;
    nchk++; if ({bus.out_v, bus.out_last, bus.frame_ok, bus.frame_err, bus.err_code, bus.out_data} !== 14'd0) begin
      nfail++; $display("FAIL rst_out got v=%b l=%b ok=%b err=%b code=%0d d=%h want 0",
                        bus.out_v, bus.out_last, bus.frame_ok, bus.frame_err, bus.err_code, bus.out_data);
    end
    idle(2);
    nrst = 1'b1;
    bus.out_rdy = 1'b1;
    clear();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    idle(6);
    nchk++; if (ok_cnt !== 1 || out_q.size() !== 2 || out_q[0] !== 9'h001 || out_q[1] !== 9'h102) begin
      nfail++; $display("FAIL rst_recover got ok=%0d n=%0d %h %h want 1 2 001 102", ok_cnt, out_q.size(), out_q[0], out_q[1]);
    end
  endtask

  initial begin
    bus.in_data = 8'h00;
    bus.in_v    = 1'b0;
    bus.out_rdy = 1'b1;
    clear();
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_badlen();
    test_max_len();
    test_overrun_stall();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
